// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Optional feature macro: STALL_CNT_EN (stall counters on the top level).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    FLUSH    = 2'd3
  } pipe_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic ctrl_sel;
    logic id_ex_write;
    logic ex_mem_write;
    logic ex_mem_bubble;
    logic mem_wb_bubble;
  } stage_ctrl_t;

  // Free-running pipeline: every stage advances, decoded control passes.
  localparam stage_ctrl_t NORMAL_CTRL = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, ctrl_sel: 1'b1,
    id_ex_write: 1'b1, ex_mem_write: 1'b1, ex_mem_bubble: 1'b0, mem_wb_bubble: 1'b0};

  // Memory wait: nothing advances, a bubble drains into WB.
  localparam stage_ctrl_t FREEZE_CTRL = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, ctrl_sel: 1'b1,
    id_ex_write: 1'b0, ex_mem_write: 1'b0, ex_mem_bubble: 1'b0, mem_wb_bubble: 1'b1};

  // Redirect: fetch continues from the new PC, wrong-path work is squashed.
  localparam stage_ctrl_t FLUSH_CTRL = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, ctrl_sel: 1'b0,
    id_ex_write: 1'b1, ex_mem_write: 1'b1, ex_mem_bubble: 1'b0, mem_wb_bubble: 1'b0};

  // Divide in flight: front end and EX held, bubbles flow on into MEM.
  localparam stage_ctrl_t DIV_CTRL = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, ctrl_sel: 1'b1,
    id_ex_write: 1'b0, ex_mem_write: 1'b1, ex_mem_bubble: 1'b1, mem_wb_bubble: 1'b0};

  // Load-use: hold PC and IF/ID for one cycle, bubble into ID/EX.
  localparam stage_ctrl_t LU_CTRL = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, ctrl_sel: 1'b0,
    id_ex_write: 1'b1, ex_mem_write: 1'b1, ex_mem_bubble: 1'b0, mem_wb_bubble: 1'b0};

  function automatic logic load_use(input logic mem_read, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2);
    return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and stage-control outputs of the stall sequencer.
// master: the sequencer; slave: the pipeline datapath.
interface pipeline_stall_ctrl_if;
  logic       ID_EX_mem_read;
  logic [4:0] ID_EX_rd;
  logic [4:0] IF_ID_rs1;
  logic [4:0] IF_ID_rs2;
  logic       EX_redirect;
  logic       EX_div_start;
  logic       EX_div_done;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_write;
  logic       IF_ID_write;
  logic       IF_ID_flush;
  logic       ctrl_sel;
  logic       ID_EX_write;
  logic       EX_MEM_write;
  logic       EX_MEM_bubble;
  logic       MEM_WB_bubble;
  logic       mem_timeout;
  logic [1:0] cur_state;

  modport master (
    input  ID_EX_mem_read, ID_EX_rd, IF_ID_rs1, IF_ID_rs2, EX_redirect,
           EX_div_start, EX_div_done, dmem_req, dmem_ready,
    output pc_write, IF_ID_write, IF_ID_flush, ctrl_sel, ID_EX_write,
           EX_MEM_write, EX_MEM_bubble, MEM_WB_bubble, mem_timeout, cur_state
  );

  modport slave (
    output ID_EX_mem_read, ID_EX_rd, IF_ID_rs1, IF_ID_rs2, EX_redirect,
           EX_div_start, EX_div_done, dmem_req, dmem_ready,
    input  pc_write, IF_ID_write, IF_ID_flush, ctrl_sel, ID_EX_write,
           EX_MEM_write, EX_MEM_bubble, MEM_WB_bubble, mem_timeout, cur_state
  );
endinterface

// File: rtl/pipe_wait_timer.sv
// 16-bit saturating up-counter: load to 1, count up to LIMIT, clear to 0.
module pipe_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic inc,
  output logic at_limit
);
  localparam logic [15:0] LIM = 16'(LIMIT);

  logic [15:0] count;

  // Wait-cycle count; holds once LIMIT is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (clear)              count <= '0;
    else if (load)               count <= 16'd1;
    else if (inc && count != LIM) count <= count + 16'd1;
  end

  assign at_limit = (count == LIM);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Priority in RUN: memory stall > redirect > divide > load-use.
// Optional macro STALL_CNT_EN adds saturating per-source stall counters.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_stall_ctrl_if.master pif
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      cnt_lu,
  output logic [CNT_W-1:0]      cnt_mem,
  output logic [CNT_W-1:0]      cnt_div,
  output logic [CNT_W-1:0]      cnt_flush
`endif
);

  localparam logic [1:0] FL_RELOAD = 2'(FLUSH_CYCLES - 1);

  pipe_state_e state_q, state_d;
  logic [1:0]  fl_cnt_q, fl_cnt_d;
  stage_ctrl_t ctrl, ctrl_out;
  logic        timeout;
  logic        lu, ms;
  logic        tmr_clear, tmr_load, tmr_inc, tmr_at_limit;
  logic        src_lu, src_mem, src_div, src_flush;

  assign lu = load_use(pif.ID_EX_mem_read, pif.ID_EX_rd, pif.IF_ID_rs1, pif.IF_ID_rs2);
  assign ms = pif.dmem_req && !pif.dmem_ready;

  pipe_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .inc      (tmr_inc),
    .at_limit (tmr_at_limit)
  );

  // State and flush-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      fl_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  // Next state, stage controls and per-source activity flags.
  always_comb begin
    state_d   = state_q;
    fl_cnt_d  = fl_cnt_q;
    ctrl      = NORMAL_CTRL;
    timeout   = 1'b0;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_inc   = 1'b0;
    src_lu    = 1'b0;
    src_mem   = 1'b0;
    src_div   = 1'b0;
    src_flush = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ms) begin
          ctrl     = FREEZE_CTRL;
          src_mem  = 1'b1;
          tmr_load = 1'b1;
          state_d  = MEM_WAIT;
        end else if (pif.EX_redirect) begin
          ctrl      = FLUSH_CTRL;
          src_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d  = FLUSH;
            fl_cnt_d = FL_RELOAD;
          end
        end else if (pif.EX_div_start && !pif.EX_div_done) begin
          ctrl    = DIV_CTRL;
          src_div = 1'b1;
          state_d = DIV_WAIT;
        end else if (lu) begin
          ctrl   = LU_CTRL;
          src_lu = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (ms && tmr_at_limit) begin
          timeout   = 1'b1;
          tmr_clear = 1'b1;
          state_d   = RUN;
        end else if (ms) begin
          ctrl    = FREEZE_CTRL;
          src_mem = 1'b1;
          tmr_inc = 1'b1;
        end else begin
          tmr_clear = 1'b1;
          state_d   = RUN;
          if (lu) begin
            ctrl   = LU_CTRL;
            src_lu = 1'b1;
          end
        end
      end
      DIV_WAIT: begin
        if (ms) begin
          ctrl    = FREEZE_CTRL;
          src_mem = 1'b1;
        end else if (pif.EX_div_done) begin
          state_d = RUN;
        end else begin
          ctrl    = DIV_CTRL;
          src_div = 1'b1;
        end
      end
      FLUSH: begin
        if (ms) begin
          ctrl    = FREEZE_CTRL;
          src_mem = 1'b1;
        end else begin
          ctrl      = FLUSH_CTRL;
          src_flush = 1'b1;
          if (pif.EX_redirect) begin
            fl_cnt_d = FL_RELOAD;
          end else if (fl_cnt_q <= 2'd1) begin
            fl_cnt_d = '0;
            state_d  = RUN;
          end else begin
            fl_cnt_d = fl_cnt_q - 2'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Reset forces every control low, including ctrl_sel, without waiting for a clock.
  always_comb begin
    ctrl_out = rst_n ? ctrl : '0;
  end

  assign pif.pc_write      = ctrl_out.pc_write;
  assign pif.IF_ID_write   = ctrl_out.if_id_write;
  assign pif.IF_ID_flush   = ctrl_out.if_id_flush;
  assign pif.ctrl_sel      = ctrl_out.ctrl_sel;
  assign pif.ID_EX_write   = ctrl_out.id_ex_write;
  assign pif.EX_MEM_write  = ctrl_out.ex_mem_write;
  assign pif.EX_MEM_bubble = ctrl_out.ex_mem_bubble;
  assign pif.MEM_WB_bubble = ctrl_out.mem_wb_bubble;
  assign pif.mem_timeout   = rst_n && timeout;
  assign pif.cur_state     = state_q;

`ifdef STALL_CNT_EN
  // Saturating count of cycles each hazard source owns the stage controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lu    <= '0;
      cnt_mem   <= '0;
      cnt_div   <= '0;
      cnt_flush <= '0;
    end else begin
      if (src_lu    && cnt_lu    != '1) cnt_lu    <= cnt_lu    + 1'b1;
      if (src_mem   && cnt_mem   != '1) cnt_mem   <= cnt_mem   + 1'b1;
      if (src_div   && cnt_div   != '1) cnt_div   <= cnt_div   + 1'b1;
      if (src_flush && cnt_flush != '1) cnt_flush <= cnt_flush + 1'b1;
    end
  end
`endif

  // Redirect and divide issue must never coincide; redirect wins in hardware.
  a_redirect_div_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(pif.EX_redirect && pif.EX_div_start));

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed-vector bench for pipeline_stall_ctrl.
// Two instances share stimulus: u_dut_a (MEM_TIMEOUT=3, FLUSH_CYCLES=3)
// and u_dut_b (defaults). Observed word per DUT:
// {pc_write, IF_ID_write, IF_ID_flush, ctrl_sel, ID_EX_write, EX_MEM_write,
//  EX_MEM_bubble, MEM_WB_bubble, mem_timeout, cur_state[1:0]}.
module tb_pipeline_stall_ctrl;

  localparam logic [7:0] C_NORM = 8'b1101_1100;
  localparam logic [7:0] C_FRZ  = 8'b0001_0001;
  localparam logic [7:0] C_FLU  = 8'b1110_1100;
  localparam logic [7:0] C_DIV  = 8'b0001_0110;
  localparam logic [7:0] C_LU   = 8'b0000_1100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read, redirect, div_start, div_done, dmem_req, dmem_ready;
  logic [4:0] rd, rs1, rs2;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if ia ();
  pipeline_stall_ctrl_if ib ();

  assign ia.ID_EX_mem_read = mem_read;   assign ib.ID_EX_mem_read = mem_read;
  assign ia.ID_EX_rd       = rd;         assign ib.ID_EX_rd       = rd;
  assign ia.IF_ID_rs1      = rs1;        assign ib.IF_ID_rs1      = rs1;
  assign ia.IF_ID_rs2      = rs2;        assign ib.IF_ID_rs2      = rs2;
  assign ia.EX_redirect    = redirect;   assign ib.EX_redirect    = redirect;
  assign ia.EX_div_start   = div_start;  assign ib.EX_div_start   = div_start;
  assign ia.EX_div_done    = div_done;   assign ib.EX_div_done    = div_done;
  assign ia.dmem_req       = dmem_req;   assign ib.dmem_req       = dmem_req;
  assign ia.dmem_ready     = dmem_ready; assign ib.dmem_ready     = dmem_ready;

`ifdef STALL_CNT_EN
  logic [31:0] cnt_lu_a, cnt_mem_a, cnt_div_a, cnt_flush_a;
  logic [31:0] cnt_lu_b, cnt_mem_b, cnt_div_b, cnt_flush_b;
`endif

  pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(3), .CNT_W(32)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .pif       (ia.master)
`ifdef STALL_CNT_EN
    ,
    .cnt_lu    (cnt_lu_a),
    .cnt_mem   (cnt_mem_a),
    .cnt_div   (cnt_div_a),
    .cnt_flush (cnt_flush_a)
`endif
  );

  pipeline_stall_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(255), .CNT_W(32)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .pif       (ib.master)
`ifdef STALL_CNT_EN
    ,
    .cnt_lu    (cnt_lu_b),
    .cnt_mem   (cnt_mem_b),
    .cnt_div   (cnt_div_b),
    .cnt_flush (cnt_flush_b)
`endif
  );

  logic [10:0] obs_a, obs_b;
  assign obs_a = {ia.pc_write, ia.IF_ID_write, ia.IF_ID_flush, ia.ctrl_sel, ia.ID_EX_write,
                  ia.EX_MEM_write, ia.EX_MEM_bubble, ia.MEM_WB_bubble, ia.mem_timeout, ia.cur_state};
  assign obs_b = {ib.pc_write, ib.IF_ID_write, ib.IF_ID_flush, ib.ctrl_sel, ib.ID_EX_write,
                  ib.EX_MEM_write, ib.EX_MEM_bubble, ib.MEM_WB_bubble, ib.mem_timeout, ib.cur_state};

  function automatic logic [10:0] v(input logic [7:0] c, input logic to, input logic [1:0] st);
    return {c, to, st};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    mem_read = 0; rd = 0; rs1 = 0; rs2 = 0;
    redirect = 0; div_start = 0; div_done = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  // Check both DUTs mid-cycle against the current inputs, then advance one clock.
  task automatic cyc(input string tag, input logic [10:0] ea, input logic [10:0] eb);
    @(negedge clk);
    check_vec({tag, "/A"}, 32'(obs_a), 32'(ea));
    check_vec({tag, "/B"}, 32'(obs_b), 32'(eb));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    dmem_req = 1;
    #7;
    check_vec("rst/A", 32'(obs_a), 32'd0);
    check_vec("rst/B", 32'(obs_b), 32'd0);
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // Load-use
    mem_read = 1; rd = 5; rs2 = 5;
    cyc("lu_rs2", v(C_LU, 0, 0), v(C_LU, 0, 0));
    idle();
    cyc("lu_after", v(C_NORM, 0, 0), v(C_NORM, 0, 0));
    mem_read = 1; rd = 0; rs1 = 0; rs2 = 0;
    cyc("lu_rd0", v(C_NORM, 0, 0), v(C_NORM, 0, 0));
    mem_read = 1; rd = 7; rs1 = 7; rs2 = 2;
    cyc("lu_rs1", v(C_LU, 0, 0), v(C_LU, 0, 0));
    mem_read = 0;
    cyc("lu_noload", v(C_NORM, 0, 0), v(C_NORM, 0, 0));

    // Memory wait (B) and timeout at 3 wait cycles (A)
    idle(); dmem_req = 1;
    cyc("mw1", v(C_FRZ, 0, 0), v(C_FRZ, 0, 0));
    cyc("mw2", v(C_FRZ, 0, 1), v(C_FRZ, 0, 1));
    cyc("mw3", v(C_FRZ, 0, 1), v(C_FRZ, 0, 1));
    cyc("mw4", v(C_NORM, 1, 1), v(C_FRZ, 0, 1));
    dmem_ready = 1; mem_read = 1; rd = 3; rs1 = 3;
    cyc("mw5", v(C_LU, 0, 0), v(C_LU, 0, 1));
    idle();
    cyc("mw6", v(C_NORM, 0, 0), v(C_NORM, 0, 0));

    // Divide with memory stall in cycle 3 and ignored redirect in cycle 5
    div_start = 1;
    cyc("dv1", v(C_DIV, 0, 0), v(C_DIV, 0, 0));
    div_start = 0;
    cyc("dv2", v(C_DIV, 0, 2), v(C_DIV, 0, 2));
    dmem_req = 1;
    cyc("dv3", v(C_FRZ, 0, 2), v(C_FRZ, 0, 2));
    dmem_req = 0;
    cyc("dv4", v(C_DIV, 0, 2), v(C_DIV, 0, 2));
    redirect = 1;
    cyc("dv5", v(C_DIV, 0, 2), v(C_DIV, 0, 2));
    redirect = 0;
    cyc("dv6", v(C_DIV, 0, 2), v(C_DIV, 0, 2));
    div_done = 1;
    cyc("dv7", v(C_NORM, 0, 2), v(C_NORM, 0, 2));
    idle();
    cyc("dv8", v(C_NORM, 0, 0), v(C_NORM, 0, 0));
    div_start = 1; div_done = 1;
    cyc("dv_1cyc", v(C_NORM, 0, 0), v(C_NORM, 0, 0));
    idle();
    cyc("dv_1cyc_nx", v(C_NORM, 0, 0), v(C_NORM, 0, 0));

    // Redirect with a second redirect in cycle 2
    redirect = 1;
    cyc("rd1", v(C_FLU, 0, 0), v(C_FLU, 0, 0));
    cyc("rd2", v(C_FLU, 0, 3), v(C_FLU, 0, 0));
    redirect = 0;
    cyc("rd3", v(C_FLU, 0, 3), v(C_NORM, 0, 0));
    cyc("rd4", v(C_FLU, 0, 3), v(C_NORM, 0, 0));
    cyc("rd5", v(C_NORM, 0, 0), v(C_NORM, 0, 0));

    // Memory stall during flush holds the flush count
    redirect = 1;
    cyc("rf1", v(C_FLU, 0, 0), v(C_FLU, 0, 0));
    redirect = 0; dmem_req = 1;
    cyc("rf2", v(C_FRZ, 0, 3), v(C_FRZ, 0, 0));
    dmem_req = 0;
    cyc("rf3", v(C_FLU, 0, 3), v(C_NORM, 0, 1));
    cyc("rf4", v(C_FLU, 0, 3), v(C_NORM, 0, 0));
    cyc("rf5", v(C_NORM, 0, 0), v(C_NORM, 0, 0));

    // Asynchronous reset during DIV_WAIT
    div_start = 1;
    cyc("rs1", v(C_DIV, 0, 0), v(C_DIV, 0, 0));
    div_start = 0;
    cyc("rs2", v(C_DIV, 0, 2), v(C_DIV, 0, 2));
    #1 rst_n = 1'b0;
    #1;
    check_vec("rst_mid/A", 32'(obs_a), 32'd0);
    check_vec("rst_mid/B", 32'(obs_b), 32'd0);
`ifdef STALL_CNT_EN
    check_vec("cnt_div/A", cnt_div_a, 32'd0);
    check_vec("cnt_div/B", cnt_div_b, 32'd0);
`endif
    #1 rst_n = 1'b1;
    cyc("post_rst", v(C_NORM, 0, 0), v(C_NORM, 0, 0));
    cyc("post_rst2", v(C_NORM, 0, 0), v(C_NORM, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
